// File: rtl/store_merge_unit.sv
// store_merge_unit: multicycle store path between the CPU datapath and data memory.
// Word stores are written directly; byte and halfword stores read the target word,
// merge the new lane(s) in, and write the word back. Illegal stores are rejected
// without touching memory.
//
// state | meaning
// IDLE  | waiting for start; request latched on acceptance
// RD    | one-cycle mem_rd strobe, latency counter loaded
// WAIT  | counting down read latency; captures and merges mem_rdata at zero
// WR    | one-cycle mem_wr strobe with the merged word
// DONE  | one-cycle done pulse
// ERR   | one-cycle misalign pulse, no memory access
module store_merge_unit #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        store_mode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              busy,
   output logic              done,
   output logic              misalign,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata
);

   localparam int OFF    = $clog2(DATA_W / 8);
   localparam int NBYTES = DATA_W / 8;
   localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

   localparam logic [1:0] MODE_SW = 2'b00;
   localparam logic [1:0] MODE_SH = 2'b01;
   localparam logic [1:0] MODE_SB = 2'b10;
   localparam logic [1:0] MODE_RS = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WAIT,
      S_WR,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state;
   state_t           state_d;
   logic [1:0]       mode_q;
   logic [OFF-1:0]   lane_q;
   logic [15:0]      data_q;
   logic [CNT_W-1:0] cnt_q;
   logic             req_err;
   logic [DATA_W-1:0] merged;

   // Reject reserved mode, odd halfword and non-word-aligned word stores.
   always_comb begin
      req_err = 1'b0;
      if (store_mode == MODE_RS)
         req_err = 1'b1;
      else if (store_mode == MODE_SH && addr[0])
         req_err = 1'b1;
      else if (store_mode == MODE_SW && addr[OFF-1:0] != '0)
         req_err = 1'b1;
   end

   // Overlay the latched byte/halfword onto the word returned by memory.
   always_comb begin
      merged = mem_rdata;
      for (int i = 0; i < NBYTES; i++) begin
         if (mode_q == MODE_SB && lane_q == OFF'(i))
            merged[8*i +: 8] = data_q[7:0];
         if (mode_q == MODE_SH && (lane_q >> 1) == OFF'(i >> 1))
            merged[8*i +: 8] = data_q[8*(i%2) +: 8];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= S_IDLE;
      else
         state <= state_d;
   end

   // Next-state selection; start is only honoured in IDLE.
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (req_err)
                  state_d = S_ERR;
               else if (store_mode == MODE_SW)
                  state_d = S_WR;
               else
                  state_d = S_RD;
            end
         end
         S_RD:   state_d = S_WAIT;
         S_WAIT: if (cnt_q == '0) state_d = S_WR;
         S_WR:   state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         S_ERR:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes and status decoded straight from the state register.
   always_comb begin
      busy     = (state != S_IDLE);
      mem_rd   = (state == S_RD);
      mem_wr   = (state == S_WR);
      done     = (state == S_DONE);
      misalign = (state == S_ERR);
   end

   // Request latch, latency counter and write-data register. mem_wdata is
   // preloaded with the source word so word stores need no further update.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mode_q    <= '0;
         lane_q    <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q    <= store_mode;
                  lane_q    <= addr[OFF-1:0];
                  data_q    <= store_data[15:0];
                  mem_addr  <= {addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                  mem_wdata <= store_data;
               end
            end
            S_RD: cnt_q <= CNT_INIT;
            S_WAIT: begin
               if (cnt_q != '0)
                  cnt_q <= cnt_q - 1'b1;
               else
                  mem_wdata <= merged;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: a 32-bit/latency-1 instance and a 64-bit/latency-3
// instance share the clock and reset. A small memory model returns a known word
// only in the cycle the configured latency says it becomes valid.
module tb_store_merge_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   logic        start32, busy32, done32, mis32, mem_rd32, mem_wr32;
   logic [1:0]  mode32;
   logic [31:0] addr32, data32, mem_addr32, mem_rdata32, mem_wdata32;

   logic        start64, busy64, done64, mis64, mem_rd64, mem_wr64;
   logic [1:0]  mode64;
   logic [31:0] addr64, mem_addr64;
   logic [63:0] data64, mem_rdata64, mem_wdata64;

   store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(1)) dut32 (
      .clk(clk), .reset_n(reset_n), .start(start32), .store_mode(mode32),
      .addr(addr32), .store_data(data32), .busy(busy32), .done(done32),
      .misalign(mis32), .mem_addr(mem_addr32), .mem_rd(mem_rd32),
      .mem_rdata(mem_rdata32), .mem_wr(mem_wr32), .mem_wdata(mem_wdata32));

   store_merge_unit #(.DATA_W(64), .ADDR_W(32), .MEM_LATENCY(3)) dut64 (
      .clk(clk), .reset_n(reset_n), .start(start64), .store_mode(mode64),
      .addr(addr64), .store_data(data64), .busy(busy64), .done(done64),
      .misalign(mis64), .mem_addr(mem_addr64), .mem_rd(mem_rd64),
      .mem_rdata(mem_rdata64), .mem_wr(mem_wr64), .mem_wdata(mem_wdata64));

   // Memory model: read data valid exactly MEM_LATENCY cycles after mem_rd.
   logic [63:0] mem_word = '0;
   logic        rdp32 = 1'b0;
   logic [2:0]  rdp64 = '0;
   always @(posedge clk) begin
      rdp32 <= mem_rd32;
      rdp64 <= {rdp64[1:0], mem_rd64};
   end
   assign mem_rdata32 = rdp32    ? mem_word[31:0] : 32'hBADBAD00;
   assign mem_rdata64 = rdp64[2] ? mem_word       : 64'hBADBAD00_BADBAD00;

   // Observation mux onto whichever instance the current vector targets.
   logic        sel;
   logic        s_busy, s_done, s_mis, s_rd, s_wr;
   logic [31:0] s_maddr;
   logic [63:0] s_wdata;
   assign s_busy  = sel ? busy64 : busy32;
   assign s_done  = sel ? done64 : done32;
   assign s_mis   = sel ? mis64  : mis32;
   assign s_rd    = sel ? mem_rd64 : mem_rd32;
   assign s_wr    = sel ? mem_wr64 : mem_wr32;
   assign s_maddr = sel ? mem_addr64 : mem_addr32;
   assign s_wdata = sel ? mem_wdata64 : {32'h0, mem_wdata32};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        sel;
      logic [1:0]  mode;
      logic [31:0] addr;
      logic [63:0] data;
      logic [63:0] word;
      logic        err;
      logic [63:0] wdata;
      logic [31:0] maddr;
      int          wr_cyc;
      int          end_cyc;
      logic        glitch;
   } vec_t;

   typedef struct {
      logic [31:0] maddr;
      logic [63:0] wdata;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];

   task automatic run_vec(input vec_t v);
      int   rd_cnt;
      bit   fin;
      bit   stray;
      exp_t e;
      sel      = v.sel;
      mem_word = v.word;
      if (!v.err) sb.push_back('{v.maddr, v.wdata, v.wr_cyc});
      @(negedge clk);
      if (v.sel) begin
         start64 = 1'b1; mode64 = v.mode; addr64 = v.addr; data64 = v.data;
      end else begin
         start32 = 1'b1; mode32 = v.mode; addr32 = v.addr; data32 = v.data[31:0];
      end
      @(negedge clk);
      start32 = 1'b0; start64 = 1'b0;
      // Scramble inputs: only the start-cycle values may matter.
      mode32 = 2'($urandom); addr32 = $urandom; data32 = $urandom;
      mode64 = 2'($urandom); addr64 = $urandom; data64 = {$urandom, $urandom};
      rd_cnt = 0;
      fin    = 0;
      for (int k = 1; k <= 20 && !fin; k++) begin
         if (s_rd) rd_cnt++;
         if (s_wr) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: got mem_wr at cycle %0d expected none", k);
            end else begin
               e = sb.pop_front();
               chk("wr_cycle", 64'(k), 64'(e.cyc));
               chk("wr_mem_addr", {32'h0, s_maddr}, {32'h0, e.maddr});
               chk("mem_wdata", s_wdata, e.wdata);
            end
         end
         if (s_done || s_mis) begin
            chk("end_cycle", 64'(k), 64'(v.end_cyc));
            chk("done", {63'h0, s_done}, {63'h0, !v.err});
            chk("misalign", {63'h0, s_mis}, {63'h0, v.err});
            chk("busy_at_end", {63'h0, s_busy}, 64'h1);
            chk("mem_addr_hold", {32'h0, s_maddr}, {32'h0, v.maddr});
            fin = 1;
         end
         if (v.glitch && k == 2) begin
            start64 = 1'b1; mode64 = 2'b00; addr64 = 32'h7000; data64 = 64'hFFFF;
         end
         if (v.glitch && k == 3) start64 = 1'b0;
         if (!fin) @(negedge clk);
      end
      if (!fin) begin
         checks++; errors++;
         $display("FAIL timeout: got no done/misalign expected one by cycle %0d", v.end_cyc);
      end
      chk("rd_count", 64'(rd_cnt), (v.err || v.mode == 2'b00) ? 64'h0 : 64'h1);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_write: got %0d pending writes expected 0", sb.size());
         sb.delete();
      end
      if (v.glitch) begin
         stray = 0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (s_busy || s_wr || s_rd) stray = 1;
         end
         chk("glitch_start_ignored", {63'h0, stray}, 64'h0);
      end
   endtask

   task automatic reset_test();
      bit wr_seen;
      sel      = 1'b1;
      mem_word = 64'h0123456789ABCDEF;
      wr_seen  = 0;
      @(negedge clk);
      start64 = 1'b1; mode64 = 2'b10; addr64 = 32'h4001; data64 = 64'hEE;
      @(negedge clk);
      start64 = 1'b0;
      if (mem_wr64) wr_seen = 1;
      @(negedge clk);
      if (mem_wr64) wr_seen = 1;
      reset_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (mem_wr64) wr_seen = 1;
      end
      reset_n = 1'b1;
      chk("rst_busy", {63'h0, busy64}, 64'h0);
      chk("rst_done", {63'h0, done64}, 64'h0);
      chk("rst_misalign", {63'h0, mis64}, 64'h0);
      chk("rst_mem_rd", {63'h0, mem_rd64}, 64'h0);
      chk("rst_mem_addr", {32'h0, mem_addr64}, 64'h0);
      chk("rst_mem_wdata", mem_wdata64, 64'h0);
      repeat (10) begin
         @(negedge clk);
         if (mem_wr64 || busy64) wr_seen = 1;
      end
      chk("rst_no_write_or_busy", {63'h0, wr_seen}, 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; sel = 1'b0;
      start32 = 1'b0; mode32 = '0; addr32 = '0; data32 = '0;
      start64 = 1'b0; mode64 = '0; addr64 = '0; data64 = '0;

      //            sel  mode   addr          data                    word                    err  wdata                   maddr         wr end glitch
      vecs.push_back('{1'b0, 2'b00, 32'h0000100C, 64'hDEADBEEF,          64'h0,                  1'b0, 64'hDEADBEEF,          32'h0000100C, 1, 2, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 32'h00002000, 64'hCDCDCDAB,          64'h11223344,           1'b0, 64'h112233AB,          32'h00002000, 3, 4, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 32'h00002001, 64'hCDCDCDAB,          64'h11223344,           1'b0, 64'h1122AB44,          32'h00002000, 3, 4, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 32'h00002002, 64'hCDCDCDAB,          64'h11223344,           1'b0, 64'h11AB3344,          32'h00002000, 3, 4, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 32'h00002003, 64'hCDCDCDAB,          64'h11223344,           1'b0, 64'hAB223344,          32'h00002000, 3, 4, 1'b0});
      vecs.push_back('{1'b0, 2'b01, 32'h00002004, 64'h5555CAFE,          64'h11223344,           1'b0, 64'h1122CAFE,          32'h00002004, 3, 4, 1'b0});
      vecs.push_back('{1'b0, 2'b01, 32'h00002006, 64'h5555CAFE,          64'h11223344,           1'b0, 64'hCAFE3344,          32'h00002004, 3, 4, 1'b0});
      vecs.push_back('{1'b0, 2'b01, 32'h00003001, 64'h1234,              64'h11223344,           1'b1, 64'h0,                 32'h00003000, 0, 1, 1'b0});
      vecs.push_back('{1'b0, 2'b00, 32'h00003002, 64'h12345678,          64'h11223344,           1'b1, 64'h0,                 32'h00003000, 0, 1, 1'b0});
      vecs.push_back('{1'b0, 2'b11, 32'h00003000, 64'h12345678,          64'h11223344,           1'b1, 64'h0,                 32'h00003000, 0, 1, 1'b0});
      vecs.push_back('{1'b1, 2'b10, 32'h00003005, 64'h5A,                64'h0123456789ABCDEF,   1'b0, 64'h01235A6789ABCDEF,  32'h00003000, 5, 6, 1'b1});
      vecs.push_back('{1'b1, 2'b01, 32'h00005006, 64'hBEEF,              64'h0123456789ABCDEF,   1'b0, 64'hBEEF456789ABCDEF,  32'h00005000, 5, 6, 1'b0});
      vecs.push_back('{1'b1, 2'b00, 32'h00005004, 64'h1122334455667788,  64'h0,                  1'b1, 64'h0,                 32'h00005000, 0, 1, 1'b0});
      vecs.push_back('{1'b1, 2'b00, 32'h00006008, 64'h1122334455667788,  64'h0,                  1'b0, 64'h1122334455667788,  32'h00006008, 1, 2, 1'b0});

      repeat (3) @(negedge clk);
      chk("init_busy32", {63'h0, busy32}, 64'h0);
      chk("init_strobes32", {60'h0, done32, mis32, mem_rd32, mem_wr32}, 64'h0);
      chk("init_mem_addr32", {32'h0, mem_addr32}, 64'h0);
      chk("init_busy64", {63'h0, busy64}, 64'h0);
      chk("init_strobes64", {60'h0, done64, mis64, mem_rd64, mem_wr64}, 64'h0);
      chk("init_mem_wdata64", mem_wdata64, 64'h0);
      reset_n = 1'b1;

      // Vectors run back to back: each start lands in the cycle after done/misalign.
      foreach (vecs[i]) run_vec(vecs[i]);

      reset_test();
      // The unit must still work normally after the interrupted store.
      run_vec(vecs[10]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Multicycle store path unit between the CPU datapath and data memory.
- Executes SW, SH and SB stores at any legal byte offset. Sub-word stores use read-modify-write: read the memory word, merge the new byte or halfword into the addressed lane, write the word back.
- Flags misaligned and reserved stores and writes nothing for them.
- Takes over store merging from the control unit; the control unit only issues start and waits for done.

Parameters:
- DATA_W, 32, memory word width; must be 32 or 64.
- ADDR_W, 32, byte address width.
- MEM_LATENCY, 1, cycles from the mem_rd cycle to mem_rdata being valid; must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request a store; sampled only in IDLE.
- store_mode  in  2  00 SW, 01 SH, 10 SB, 11 reserved.
- addr  in  ADDR_W  byte address of the store.
- store_data  in  DATA_W  source register value (B); SB uses bits [7:0], SH uses [15:0], SW uses all bits.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when a store completes successfully.
- misalign  out  1  one-cycle pulse when a store is rejected.
- mem_addr  out  ADDR_W  word-aligned address: latched addr with the low OFF bits cleared, OFF = log2(DATA_W/8).
- mem_rd  out  1  memory read strobe.
- mem_rdata  in  DATA_W  memory read data.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  merged word to write.

Behaviour:
- States: IDLE, RD, WAIT, WR, DONE, ERR.
- Reset (reset_n=0 at a clock edge): state IDLE; busy, done, misalign, mem_rd and mem_wr all 0; mem_addr, mem_wdata and internal registers 0. Reset applies from any state. A store interrupted by reset must never produce mem_wr.
- IDLE, start=1: latch store_mode, addr and store_data; busy=1 from the next cycle.
  - Error condition: mode 11, SH with addr[0]=1, or SW with addr[OFF-1:0]≠0. Go to ERR.
  - SW with no error: go to WR, skipping the read.
  - SH or SB with no error: go to RD.
- RD: mem_rd=1 for exactly one cycle, then go to WAIT. The WAIT counter is loaded with MEM_LATENCY-1.
- WAIT: mem_rd=0. While the counter is nonzero, decrement it. When it reaches 0, capture mem_rdata into the merge register and go to WR.
- WR: mem_wr=1 for exactly one cycle; mem_wdata holds the merged word; then go to DONE.
  - SW: mem_wdata = store_data.
  - SB: byte lane k = addr[OFF-1:0] (little-endian, lane 0 = bits [7:0]) is replaced with store_data[7:0]; all other lanes come from the captured word.
  - SH: halfword lane addr[OFF-1:1] is replaced with store_data[15:0]; all other lanes come from the captured word.
- DONE: done=1 and busy=1 for this one cycle; then go to IDLE.
- ERR: misalign=1 and busy=1 for one cycle; no mem_rd or mem_wr is issued; then go to IDLE.
- start while busy is ignored; there is no queuing. Input changes after the start cycle have no effect.
- Latency with MEM_LATENCY=1, start accepted at T0:
  - SW: WR at T1, done at T2.
  - SB/SH: RD at T1, WAIT at T2, WR at T3, done at T4.
  - Each extra latency cycle adds one WAIT cycle.
- A start in the cycle after done or misalign (back in IDLE) is accepted; the minimum spacing between starts is the full operation length.
- mem_addr holds its value from the cycle after start through DONE/ERR.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles in mid-WAIT of an SB -> no mem_wr ever; busy=0, state IDLE; all outputs 0 after release.
- SW aligned: DATA_W=32, addr=0x100C, data 0xDEADBEEF -> mem_wr at T1 with mem_addr=0x100C and mem_wdata=0xDEADBEEF; done at T2; mem_rd never asserted.
- SB each lane: memory word 0x11223344, data 0xAB, addr offsets 0..3 -> mem_wdata 0x112233AB, 0x1122AB44, 0x11AB3344, 0xAB223344; done at T4.
- SH both lanes: memory word 0x11223344, data 0xCAFE, offsets 0 and 2 -> mem_wdata 0x1122CAFE and 0xCAFE3344.
- Misaligned and reserved: SH at offset 1, SW at offset 2, mode 11 -> misalign pulse at T1; no mem_rd or mem_wr; done stays 0.
- MEM_LATENCY=3 with DATA_W=64: SB at offset 5, memory word 0x0123456789ABCDEF, data 0x5A -> mem_wdata 0x01235A6789ABCDEF; WR at T5, done at T6. A start pulse at T2 is ignored.
